// File: rtl/cdc_gray_pkg.sv
// Shared definitions for Gray-coded pointer crossings.
// The transmit and receive sides both use these code conversions and checks.
package cdc_gray_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEEK = 1'b1
    } state_t;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down. Narrower pointers are zero-extended,
    // so the unused upper bits do not affect the result.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when more than one bit is set. Clearing the lowest set bit
    // leaves a nonzero value only in that case.
    function automatic logic multi_bit(input logic [MAX_W-1:0] x);
        return (x & (x - MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/cdc_gray_step_check.sv
// Sticky monitor that flags any cycle in which a Gray pointer moves by more than one bit.
// It works on either side of a crossing (before or after synchronization).
module cdc_gray_step_check
    import cdc_gray_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] gray_i,
    output logic             step_err_o
);

    logic [WIDTH-1:0] prev_q;
    logic             err_q;
    logic             err_d;

    always_comb begin
        err_d = err_q | multi_bit(MAX_W'(gray_i ^ prev_q));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= gray_i;
            err_q  <= err_d;
        end
    end

    assign step_err_o = err_q;

endmodule

// File: rtl/cdc_gray_ptr_tx.sv
// Source-side Gray pointer transmitter. The count moves forward by at most one per cycle,
// and gray_out is taken directly from a flop, so it is safe to feed into a two-flop synchronizer.
module cdc_gray_ptr_tx
    import cdc_gray_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_a,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             seek_req,
    input  logic [WIDTH-1:0] seek_target,
    output logic             busy,
    output logic             seek_done,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             step_err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] bin_inc;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             advance;

    assign bin_inc = bin_q + WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        case (state_q)
            IDLE: begin
                if (seek_req) begin
                    // A zero-distance seek completes immediately and never raises busy.
                    if (seek_target != bin_q) begin
                        target_d = seek_target;
                        state_d  = SEEK;
                        busy_d   = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (inc) begin
                    advance = 1'b1;
                end
            end
            SEEK: begin
                advance = 1'b1;
                if (bin_inc == target_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        bin_d  = advance ? bin_inc : bin_q;
        wrap_d = advance & (&bin_q);
        // Encode the next binary value so gray_out is a clean flop output.
        gray_d = WIDTH'(bin2gray(MAX_W'(bin_d)));
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    // The target is only read while in SEEK, so it needs no reset.
    always_ff @(posedge clk_a) begin
        target_q <= target_d;
    end

    cdc_gray_step_check #(
        .WIDTH (WIDTH)
    ) u_step_check (
        .clk_i      (clk_a),
        .rst_ni     (rst_n),
        .gray_i     (gray_q),
        .step_err_o (step_err)
    );

    assign busy      = busy_q;
    assign seek_done = done_q;
    assign bin_out   = bin_q;
    assign gray_out  = gray_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_cdc_gray_ptr_tx.sv
// Bench for cdc_gray_ptr_tx at WIDTH=4. It uses directed seek/wrap/reset scenarios plus random traffic,
// and compares every output against a distance-counting model on every cycle.
module tb_cdc_gray_ptr_tx;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk_a;
    logic         rst_n;
    logic         inc;
    logic         seek_req;
    logic [W-1:0] seek_target;
    logic         busy;
    logic         seek_done;
    logic [W-1:0] bin_out;
    logic [W-1:0] gray_out;
    logic         wrap;
    logic         step_err;

    int checks = 0;
    int errors = 0;

    // Model: count value, plus the number of steps still owed to an accepted seek.
    int   cnt    = 0;
    int   remain = 0;
    bit   m_done = 0;
    bit   m_wrap = 0;
    logic [W-1:0] prev_gray = '0;

    cdc_gray_ptr_tx #(.WIDTH(W)) dut (
        .clk_a       (clk_a),
        .rst_n       (rst_n),
        .inc         (inc),
        .seek_req    (seek_req),
        .seek_target (seek_target),
        .busy        (busy),
        .seek_done   (seek_done),
        .bin_out     (bin_out),
        .gray_out    (gray_out),
        .wrap        (wrap),
        .step_err    (step_err)
    );

    initial begin
        clk_a = 1'b0;
        forever #5 clk_a = ~clk_a;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit i_inc, input bit i_req, input int tgt);
        m_done = 0;
        m_wrap = 0;
        if (remain > 0) begin
            cnt = (cnt + 1) % M;
            remain--;
            m_wrap = (cnt == 0);
            m_done = (remain == 0);
        end else if (i_req) begin
            remain = (tgt - cnt + M) % M;
            m_done = (remain == 0);
        end else if (i_inc) begin
            cnt = (cnt + 1) % M;
            m_wrap = (cnt == 0);
        end
    endtask

    task automatic check_all();
        chk("bin", 32'(bin_out), 32'(cnt));
        chk("gray", 32'(gray_out), 32'(cnt ^ (cnt >> 1)));
        chk("busy", 32'(busy), 32'(remain > 0));
        chk("seek_done", 32'(seek_done), 32'(m_done));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("step_err", 32'(step_err), 32'd0);
        chk("gray_hamming_le1", 32'($countones(gray_out ^ prev_gray) <= 1), 32'd1);
        prev_gray = gray_out;
    endtask

    task automatic step(input bit i_inc, input bit i_req, input logic [W-1:0] i_tgt);
        inc         = i_inc;
        seek_req    = i_req;
        seek_target = i_tgt;
        @(posedge clk_a);
        model(i_inc, i_req, int'(i_tgt));
        #1;
        check_all();
    endtask

    // Issue a seek, then run until busy drops, with a bounded number of cycles.
    // Optionally drive random inc/seek_req while busy.
    task automatic run_seek(input logic [W-1:0] tgt, input int exp_d, input bit distract);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        step(1'b0, 1'b1, tgt);
        if (busy) busy_cnt++;
        if (seek_done) done_cnt++;
        for (int k = 0; k < 40 && busy; k++) begin
            if (distract) step(1'($urandom), 1'($urandom), W'($urandom));
            else          step(1'b0, 1'b0, '0);
            if (busy) busy_cnt++;
            if (seek_done) done_cnt++;
        end
        chk("seek_busy_cycles", 32'(busy_cnt), 32'(exp_d));
        chk("seek_done_pulses", 32'(done_cnt), 32'd1);
        chk("seek_final_bin", 32'(bin_out), 32'(tgt));
    endtask

    // Assert reset away from any clock edge and check that the outputs clear asynchronously.
    task automatic do_reset();
        #2;
        rst_n       = 1'b0;
        inc         = 1'b0;
        seek_req    = 1'b0;
        seek_target = '0;
        #1;
        cnt = 0; remain = 0; m_done = 0; m_wrap = 0;
        prev_gray = '0;
        check_all();
        chk("rst_async_bin", 32'(bin_out), 32'd0);
        @(negedge clk_a);
        rst_n = 1'b1;
    endtask

    int gtab [5];

    initial begin
        gtab = '{1, 3, 2, 6, 7};
        rst_n       = 1'b0;
        inc         = 1'b0;
        seek_req    = 1'b0;
        seek_target = '0;
        #1;
        check_all();
        @(negedge clk_a);
        rst_n = 1'b1;

        // Five increments walk through the first Gray codes.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, '0);
            chk("inc_gray_seq", 32'(gray_out), 32'(gtab[i]));
        end

        // Seek to 14, then increment across the wrap.
        run_seek(4'd14, 9, 1'b0);
        step(1'b1, 1'b0, '0);
        chk("pre_wrap_gray", 32'(gray_out), 32'd8);
        chk("pre_wrap_flag", 32'(wrap), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("wrap_bin", 32'(bin_out), 32'd0);
        chk("wrap_flag", 32'(wrap), 32'd1);

        // Backward target from 3 wraps forward through 15 -> 0 -> 1.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        run_seek(4'd1, 14, 1'b0);

        // Seek to 7, then a zero-distance seek.
        run_seek(4'd7, 6, 1'b0);
        run_seek(4'd7, 0, 1'b0);
        chk("eq_seek_bin", 32'(bin_out), 32'd7);

        // Distractions during a seek must not change its length.
        run_seek(4'd2, 11, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            step(r < 6, r == 0, W'($urandom));
        end

        // Reset while seeking at bin_out = 9.
        do_reset();
        step(1'b0, 1'b1, 4'd12);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0);
        chk("midseek_bin", 32'(bin_out), 32'd9);
        chk("midseek_busy", 32'(busy), 32'd1);
        do_reset();
        step(1'b1, 1'b0, '0);
        chk("post_rst_bin", 32'(bin_out), 32'd1);
        step(1'b0, 1'b0, '0);
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_gray_ptr_tx.md
# cdc_gray_ptr_tx

Source-domain transmitter for Gray-coded pointer crossings. It holds a binary counter and drives a registered Gray-coded copy that changes by at most one bit per clock, so a destination-domain two-flop synchronizer and Gray-to-binary decoder can sample it safely. Counts advance by single increments or by a forward-only "seek" toward a target, which turns arbitrary jumps into one-step-per-cycle sequences. It sits in the clk_a domain, directly feeding the synchronizer flops on the clk_b side.

## Interface
- WIDTH, 32, counter/pointer width in bits (legal range 2..32)
- clk_a  input  1  source-domain clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- inc  input  1  advance count by one this cycle (honoured only in IDLE)
- seek_req  input  1  request forward stepping to seek_target (sampled only in IDLE)
- seek_target  input  WIDTH  target count, captured when seek_req is accepted
- busy  output  1  high while in SEEK
- seek_done  output  1  one-cycle pulse when a seek completes
- bin_out  output  WIDTH  current binary count (registered)
- gray_out  output  WIDTH  registered Gray code of bin_out, the only signal allowed to cross domains
- wrap  output  1  one-cycle pulse when the count steps from all-ones to zero
- step_err  output  1  sticky: gray_out changed by more than one bit between consecutive cycles

## Operation
- Gray encoding: gray = bin ^ (bin >> 1). gray_out is a flop driven from the next binary value, never from combinational logic after the flop.
- Arithmetic is modulo 2^WIDTH. Increment of all-ones yields zero and pulses wrap.
- FSM states: IDLE, SEEK.
- IDLE:
  - seek_req=1 and seek_target != bin_out: capture the target, go to SEEK, and set busy=1 next cycle. inc is ignored in that cycle.
  - seek_req=1 and seek_target == bin_out: no count change and no state change. seek_done pulses next cycle.
  - seek_req=0 and inc=1: bin_out advances by one.
- SEEK: each cycle bin_out advances by one, forward only and wrapping through zero if needed. The cycle in which the next value equals the captured target returns the FSM to IDLE, with busy=0 and seek_done=1 in the following cycle. inc and seek_req are ignored while busy.
- Maximum seek length is 2^WIDTH-1 steps.
- The count never decrements and never changes by more than one per cycle, so gray_out has a Hamming distance of at most 1 per cycle.
- step_err: compares gray_out against its previous-cycle value. It sets if popcount of the XOR exceeds 1 and holds until reset. In a correct design it is never set; it exists as a verification hook.
- Reset, at any time including mid-seek: bin_out=0, gray_out=0, FSM=IDLE, busy=0, seek_done=0, wrap=0, step_err=0. Any pending seek is discarded.

## Timing
- inc sampled at edge N: bin_out and gray_out show the new value after edge N.
- wrap is asserted in the same cycle that bin_out first reads 0.
- Seek of distance D ≥ 1, with seek_req accepted at edge N:
  - busy is high from after N.
  - Steps land at edges N+1..N+D.
  - busy falls and seek_done pulses after edge N+D.
  - A new inc or seek_req is accepted from edge N+D+1.
- Seek with D = 0: seek_done pulses after edge N, and busy stays low.
- All outputs are registered. There is no combinational input-to-output path.

## Structure
- Shared package cdc_gray_pkg holds:
  - the functions bin2gray and gray2bin, the latter also reused by the receive side
  - the state typedef (enum IDLE, SEEK)
- One sub-module, cdc_gray_step_check, implements the Hamming-distance monitor that produces step_err. It is reusable on the receive side after synchronization.

## Test plan
- Reset then inc=1 for 5 cycles: bin_out 1..5, and gray_out sequence 1,3,2,6,7. step_err stays 0.
- WIDTH=4, load to 14 via seek, then inc twice: bin_out 15 then 0, gray_out 8 then 0, and wrap pulses on the 0 cycle.
- From bin_out=3, seek_req with target=1 (WIDTH=4): busy for 14 steps through 15→0→1, seek_done pulses once, and every gray step has Hamming distance 1.
- seek_req with target equal to bin_out=7: seek_done pulses next cycle, busy never asserts, and the count is unchanged.
- During a seek, drive inc=1 and a second seek_req: both are ignored, and the first target is reached with the original cycle count.
- rst_n low mid-seek at bin_out=9: all outputs return to 0 asynchronously, and after release inc=1 gives bin_out=1.
